// File: rtl/serial_add8_pkg.sv
// serial_add8_pkg: shared definitions for the bit-serial adder slice.
//   SERIAL_ADD8_WIDTH : default operand/result width
//   state_t           : controller states IDLE / RUN / DONE
//   cnt_width()       : bit-counter width able to hold 0..WIDTH
package serial_add8_pkg;

  localparam int SERIAL_ADD8_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/serial_add8_fa.sv
// full_adder_bit: 1-bit combinational full adder, the only arithmetic cell
// of the serial adder.
//   a, b, cin : addend bits and carry-in
//   s, cout   : sum bit and carry-out
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add8.sv
// serial_add8: bit-serial adder computing sum = a + b + cin, LSB first,
// one bit per clock through a single full adder and a carry flop.
//   clk, rst_n     : clock, asynchronous active-low reset
//   start          : request, accepted only while ready=1
//   a, b, cin      : operands, sampled on the accepting edge
//   ready          : high in IDLE only
//   busy           : high in RUN and DONE
//   sum, cout      : result and carry out of the MSB, held until next result
//   valid          : one-cycle pulse when sum/cout are updated
//   ovf            : signed overflow, present only with SERIAL_ADD_OVF_EN
module serial_add8
  import serial_add8_pkg::*;
#(
  parameter int WIDTH = SERIAL_ADD8_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             valid
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int              CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] sh_s;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s;
  logic             fa_c;

  full_adder_bit u_fa (
    .a    (sh_a[0]),
    .b    (sh_b[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ready <= 1'b1;
      busy  <= 1'b0;
      valid <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      sh_a  <= '0;
      sh_b  <= '0;
      sh_s  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
`ifdef SERIAL_ADD_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sh_a  <= a;
            sh_b  <= b;
            carry <= cin;
            cnt   <= '0;
            state <= RUN;
            ready <= 1'b0;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          sh_a  <= {1'b0, sh_a[WIDTH-1:1]};
          sh_b  <= {1'b0, sh_b[WIDTH-1:1]};
          sh_s  <= {fa_s, sh_s[WIDTH-1:1]};
          carry <= fa_c;
          cnt   <= cnt + CW'(1);
          // Last bit: publish the fully assembled word directly so sum,
          // cout and valid all change on the same edge.
          if (cnt == LAST) begin
            sum   <= {fa_s, sh_s[WIDTH-1:1]};
            cout  <= fa_c;
`ifdef SERIAL_ADD_OVF_EN
            // carry still holds the carry into the MSB at this point
            ovf   <= carry ^ fa_c;
`endif
            valid <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add8.sv
module tb_serial_add8;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         ready;
  logic         busy;
  logic [W-1:0] sum;
  logic         cout;
  logic         valid;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;
`endif

  always #5 clk = ~clk;

  serial_add8 #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .ready (ready),
    .busy  (busy),
    .sum   (sum),
    .cout  (cout),
    .valid (valid)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } exp_t;

  exp_t sb[$];
  int   acc_q[$];
  int   cyc = 0;
  int   free_at = 0;   // first pre-edge cycle at which a new start may be accepted
  int   checks = 0;
  int   failures = 0;
  bit   held_mode = 1'b0;
  int   held_cnt = 0;

  // Reference: plain integer arithmetic, unsigned and signed views.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic ci);
    exp_t r;
    int   u;
    int   sg;
    u  = int'(x) + int'(y) + int'(ci);
    sg = int'($signed(x)) + int'($signed(y)) + int'(ci);
    r.s = u[W-1:0];
    r.c = (u >= (1 << W));
    r.o = (sg > (1 << (W-1)) - 1) || (sg < -(1 << (W-1)));
    return r;
  endfunction

  function automatic void check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Issue side: an operation is accepted whenever start is high and the
  // model says the unit is idle; the expected result is queued right away.
  always @(posedge clk) begin
    if (rst_n && start && (cyc >= free_at)) begin
      sb.push_back(model(a, b, cin));
      acc_q.push_back(cyc);
      free_at = cyc + W + 2;
    end
    cyc++;
  end

  // Monitor: handshake levels every cycle, results on each valid.
  exp_t mon_e;
  int   mon_acc;
  always @(negedge clk) begin
    if (rst_n) begin
      check("ready", ready, (cyc >= free_at));
      check("busy", busy, (cyc < free_at));
      if (valid) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_valid actual=1 required=0 (cycle %0d)", cyc);
        end else begin
          mon_e   = sb.pop_front();
          mon_acc = acc_q.pop_front();
          check("latency", cyc - 1 - mon_acc, W);
          check("sum", sum, mon_e.s);
          check("cout", cout, mon_e.c);
`ifdef SERIAL_ADD_OVF_EN
          check("ovf", ovf, mon_e.o);
`endif
          if (held_mode) held_cnt++;
        end
      end else if (acc_q.size() > 0 && (cyc - 1 - acc_q[0]) > W) begin
        checks++;
        failures++;
        $display("FAIL valid_missing actual=0 required=1 (accepted at %0d, now %0d)",
                 acc_q[0], cyc);
        void'(sb.pop_front());
        void'(acc_q.pop_front());
      end
    end
  end

  // Drive one request; returns at the negedge just after the accepting edge.
  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    @(negedge clk);
    while (cyc < free_at) @(negedge clk);
    a = x;
    b = y;
    cin = ci;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    cin = 1'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drained", sb.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] x;
    logic [W-1:0] y;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready", ready, 1);
    check("rst_busy", busy, 0);
    check("rst_valid", valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    rst_n = 1'b1;

    // Directed cases
    do_op(8'h05, 8'h03, 1'b0);
    do_op(8'hFF, 8'h01, 1'b0);
    do_op(8'hEB, 8'h25, 1'b0);
    do_op(8'h7F, 8'h01, 1'b0);
    do_op(8'h80, 8'h80, 1'b0);
    do_op(8'hFF, 8'hFF, 1'b1);
    do_op(8'h00, 8'h00, 1'b1);
    drain();

    // start pulses at cycles 3 and 9 of an operation are ignored
    do_op(8'h12, 8'h34, 1'b1);
    repeat (2) @(negedge clk);
    a = 8'hAA; b = 8'h55; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    a = 8'h77; b = 8'h11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();

    // start held high: one operation every W+2 cycles
    @(negedge clk);
    while (cyc < free_at) @(negedge clk);
    held_mode = 1'b1;
    held_cnt = 0;
    a = 8'h3C; b = 8'hC5; cin = 1'b1; start = 1'b1;
    repeat (5 * (W + 2)) @(negedge clk);
    start = 1'b0;
    drain();
    held_mode = 1'b0;
    check("held_count", held_cnt, 5);

    // Reset in the middle of RUN
    do_op(8'h9A, 8'h21, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_sum", sum, 0);
    check("abort_cout", cout, 0);
    check("abort_ready", ready, 1);
    check("abort_busy", busy, 0);
    check("abort_valid", valid, 0);
    sb.delete();
    acc_q.delete();
    free_at = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 4) @(negedge clk);
    do_op(8'h40, 8'h02, 1'b1);
    drain();

    // Subtract-then-add round trip over random A/B pairs
    for (int i = 0; i < 250; i++) begin
      x = W'($urandom);
      y = W'($urandom);
      do_op(x - y, y, 1'b0);
    end
    drain();

    // Fully random operands including carry-in
    for (int i = 0; i < 40; i++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom));
    end
    drain();

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
